pcm_capture: RTL



---
 rtl/audio_pkg.sv | 36 +++
 rtl/capture_fifo.sv | 104 ++++++++++
 rtl/pcm_capture.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Definitions shared by the audio capture path:
//   - cap_state_t : byte-writer FSM states. The states walk the byte order
//                   L[7:0], L[15:8], R[7:0], R[15:8].
//   - FRAME_*     : bytes per frame for each stereo/width mode.
//   - FIFO_AW_DEFAULT / ALMOST_FULL_DEFAULT : default capture FIFO geometry.
//   - frame_size(): maps the mode bits to a byte count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package audio_pkg;

  localparam int FIFO_AW_DEFAULT     = 10;
  localparam int ALMOST_FULL_DEFAULT = 768;

  localparam logic [2:0] FRAME_16S = 3'd4;
  localparam logic [2:0] FRAME_16M = 3'd2;
  localparam logic [2:0] FRAME_8S  = 3'd2;
  localparam logic [2:0] FRAME_8M  = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_L_LO = 3'd1,
    ST_WR_L_HI = 3'd2,
    ST_WR_R_LO = 3'd3,
    ST_WR_R_HI = 3'd4
  } cap_state_t;

  function automatic logic [2:0] frame_size(input logic stereo, input logic b16);
    logic [2:0] f;
    if (b16) f = stereo ? FRAME_16S : FRAME_16M;
    else     f = stereo ? FRAME_8S  : FRAME_8M;
    return f;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// -----------------------------------------------------------------------------
// capture_fifo
// Synchronous first-word-fall-through byte FIFO. Storage is an inferred RAM
// with a registered read port. A small head register bypasses the RAM when a
// byte is written into the slot that is about to become the head.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous flush; a write or read in the same cycle
//                       is discarded
//   wr_en, wr_data    : push one byte (refused when full unless popping too)
//   rd_en             : pop one byte (ignored when empty)
//   rd_data           : head byte, valid whenever !empty
//   empty, full, almost_full, count : occupancy status
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module capture_fifo #(
  parameter int AW              = 10,
  parameter int ALMOST_FULL_LVL = 768
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          almost_full,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_ram_q;
  logic [7:0]    r_head;
  logic          r_use_ram;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_do_rd;
  logic          w_do_wr;
  logic [AW-1:0] w_rd_ptr_next;

  assign w_empty = (r_count == '0);
  // count never exceeds DEPTH, so the MSB alone marks "full"
  assign w_full  = r_count[AW];

  assign w_do_rd = rd_en && !w_empty && !flush;
  assign w_do_wr = wr_en && (!w_full || w_do_rd) && !flush;

  assign w_rd_ptr_next = w_do_rd ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  // RAM: write port plus registered read of the upcoming head address
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    r_ram_q <= r_mem[w_rd_ptr_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_head    <= '0;
      r_use_ram <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_head    <= '0;
      r_use_ram <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_next;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // The byte being written lands exactly in the next head slot (write
      // into empty, or pop of the last byte with a write alongside): the
      // RAM read this cycle would return the old contents, so capture the
      // write data directly.
      if (w_do_wr && (w_rd_ptr_next == r_wr_ptr)) begin
        r_head    <= wr_data;
        r_use_ram <= 1'b0;
      end else if (w_do_rd) begin
        r_use_ram <= 1'b1;
      end
    end
  end

  assign rd_data     = r_use_ram ? r_ram_q : r_head;
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign almost_full = (int'(r_count) >= ALMOST_FULL_LVL);

endmodule

// File: rtl/pcm_capture.sv
// -----------------------------------------------------------------------------
// pcm_capture
// Audio capture writer. Decimates the base-rate next_sample strobe with the
// shared 8-bit rate accumulator, latches left/right (or their mono mix) and
// writes the frame as bytes L[7:0], L[15:8], R[7:0], R[15:8] into the capture
// FIFO, omitting fields according to the mode bits.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   next_sample                : one-cycle base-rate strobe
//   enable                     : capture enable
//   sample_rate                : accumulator increment (128 = every strobe)
//   mode_stereo, mode_16bit    : frame format, sampled at frame start
//   left_in, right_in          : signed 16-bit audio
//   fifo_reset                 : flush FIFO, abort frame, clear overflow
//   fifo_read                  : pop one byte
//   fifo_rddata, fifo_empty, fifo_almost_full, fifo_full, fifo_count : FIFO
//   overflow                   : sticky dropped-frame flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pcm_capture
  import audio_pkg::*;
#(
  parameter int FIFO_AW         = FIFO_AW_DEFAULT,
  parameter int ALMOST_FULL_LVL = ALMOST_FULL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_sample,
  input  logic               enable,
  input  logic [7:0]         sample_rate,
  input  logic               mode_stereo,
  input  logic               mode_16bit,
  input  logic [15:0]        left_in,
  input  logic [15:0]        right_in,
  input  logic               fifo_reset,
  input  logic               fifo_read,
  output logic [7:0]         fifo_rddata,
  output logic               fifo_empty,
  output logic               fifo_almost_full,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int LP_DEPTH = 1 << FIFO_AW;

  logic [7:0]  r_acc;
  logic        r_acc7_prev;
  logic        r_ns;
  cap_state_t  r_state;
  logic [15:0] r_left;
  logic [15:0] r_right;
  logic        r_stereo;
  logic        r_16bit;
  logic        r_overflow;

  logic        w_capture_evt;
  logic [2:0]  w_frame_size;
  logic        w_space_ok;
  logic [16:0] w_sum;
  logic [15:0] w_mono;
  logic        w_wr_en;
  logic [7:0]  w_wr_data;

  // Rate generation: a capture happens whenever accumulator bit 7 toggles.
  // Not touched by fifo_reset so the sample phase survives a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_acc7_prev <= 1'b0;
      r_ns        <= 1'b0;
    end else begin
      r_ns <= next_sample;
      if (next_sample) begin
        r_acc       <= r_acc + sample_rate;
        r_acc7_prev <= r_acc[7];
      end
    end
  end

  assign w_capture_evt = r_ns && (r_acc7_prev != r_acc[7]);

  // 17-bit sum cannot overflow; dropping bit 0 is an arithmetic shift that
  // rounds toward negative infinity.
  assign w_sum  = {left_in[15], left_in} + {right_in[15], right_in};
  assign w_mono = w_sum[16:1];

  assign w_frame_size = frame_size(mode_stereo, mode_16bit);
  assign w_space_ok   = (int'(fifo_count) + int'(w_frame_size)) <= LP_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_left     <= '0;
      r_right    <= '0;
      r_stereo   <= 1'b0;
      r_16bit    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (fifo_reset) begin
      r_state    <= ST_IDLE;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture_evt && enable) begin
            if (w_space_ok) begin
              r_left   <= mode_stereo ? left_in : w_mono;
              r_right  <= right_in;
              r_stereo <= mode_stereo;
              r_16bit  <= mode_16bit;
              r_state  <= mode_16bit ? ST_WR_L_LO : ST_WR_L_HI;
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
        ST_WR_L_LO: r_state <= ST_WR_L_HI;
        ST_WR_L_HI: begin
          if (r_stereo) r_state <= r_16bit ? ST_WR_R_LO : ST_WR_R_HI;
          else          r_state <= ST_IDLE;
        end
        ST_WR_R_LO: r_state <= ST_WR_R_HI;
        ST_WR_R_HI: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
      // A new sample arriving while a frame is still being written is lost
      if ((r_state != ST_IDLE) && w_capture_evt) r_overflow <= 1'b1;
    end
  end

  // Every non-idle state writes exactly one byte
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = 8'h00;
    case (r_state)
      ST_WR_L_LO: begin w_wr_en = 1'b1; w_wr_data = r_left[7:0];   end
      ST_WR_L_HI: begin w_wr_en = 1'b1; w_wr_data = r_left[15:8];  end
      ST_WR_R_LO: begin w_wr_en = 1'b1; w_wr_data = r_right[7:0];  end
      ST_WR_R_HI: begin w_wr_en = 1'b1; w_wr_data = r_right[15:8]; end
      default:    ;
    endcase
  end

  capture_fifo #(
    .AW              (FIFO_AW),
    .ALMOST_FULL_LVL (ALMOST_FULL_LVL)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (fifo_reset),
    .wr_en       (w_wr_en),
    .wr_data     (w_wr_data),
    .rd_en       (fifo_read),
    .rd_data     (fifo_rddata),
    .empty       (fifo_empty),
    .almost_full (fifo_almost_full),
    .full        (fifo_full),
    .count       (fifo_count)
  );

  assign overflow = r_overflow;

endmodule
